// File: rtl/mux_pkg.sv
// Shared constants and the select decoder for the registered 8-to-1 bit multiplexer.
// Both the select sub-module and the top import from here.
package mux_pkg;

   localparam int N_IN  = 8;
   localparam int SEL_W = 3;

   // Map a 3-bit index onto an 8-bit one-hot vector.
   function automatic logic [N_IN-1:0] onehot3(input logic [SEL_W-1:0] sel);
      logic [N_IN-1:0] vec;
      vec = '0;
      vec[sel] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/mux_8x1_sel.sv
// Combinational bit select: one-hot decode of s, then a flat AND-OR across the data bits.
// Every candidate has the same depth, so there is no priority chain.
module mux_8x1_sel
   import mux_pkg::*;
(
   input  logic [N_IN-1:0]  d,
   input  logic [SEL_W-1:0] s,
   output logic             sel_bit
);

   logic [N_IN-1:0] onehot;
   logic [N_IN-1:0] term;

   assign onehot = onehot3(s);

   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_term
         assign term[gi] = onehot[gi] & d[gi];
      end
   endgenerate

   assign sel_bit = |term;

endmodule

// File: rtl/mux_8x1.sv
// Registered 8-to-1 single-bit multiplexer with load enable and a matching valid flag.
// Y and VLD update one cycle after an EN-qualified edge; RST overrides EN.
module mux_8x1
   import mux_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [N_IN-1:0]  D,
   input  logic [SEL_W-1:0] S,
   output logic             Y,
   output logic             VLD
);

   logic sel_bit;
   logic y_reg;
   logic vld_reg;

   mux_8x1_sel u_sel (
      .d       (D),
      .s       (S),
      .sel_bit (sel_bit)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         y_reg   <= RST_VAL;
         vld_reg <= 1'b0;
      end else begin
         if (EN) begin
            y_reg <= sel_bit;
         end
         vld_reg <= EN;
      end
   end

   assign Y   = y_reg;
   assign VLD = vld_reg;

   // Simulation-only checks; synthesis ignores concurrent assertions.
   a_vld_source : assert property (@(posedge CLK)
      VLD |-> ($past(EN) && !$past(RST)));

   a_y_matches : assert property (@(posedge CLK)
      VLD |-> (Y == $past(D[S])));

   a_no_x_on_load : assert property (@(posedge CLK)
      EN |-> !$isunknown({S, D}));

endmodule

// File: tb/tb_mux_8x1.sv
// Directed bench for mux_8x1: one step per clock, outputs sampled 1ns after the rising edge.
// Expected values are hand-derived from the select index and data pattern of each step.
module tb_mux_8x1;

   logic       CLK;
   logic       RST;
   logic       EN;
   logic [7:0] D;
   logic [2:0] S;
   logic       Y;
   logic       VLD;

   int errors = 0;
   int checks = 0;

   mux_8x1 dut (
      .CLK (CLK),
      .RST (RST),
      .EN  (EN),
      .D   (D),
      .S   (S),
      .Y   (Y),
      .VLD (VLD)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Apply one set of inputs, clock once, then check both outputs.
   task automatic step(input string tag, input logic rst, input logic en,
                       input logic [7:0] d, input logic [2:0] s,
                       input logic exp_y, input logic exp_vld);
      RST = rst;
      EN  = en;
      D   = d;
      S   = s;
      @(posedge CLK);
      #1;
      chk({tag, ".Y"}, Y, exp_y);
      chk({tag, ".VLD"}, VLD, exp_vld);
      $display("step %-10s rst=%b en=%b d=%h s=%0d -> Y=%b VLD=%b (exp %b/%b)",
               tag, rst, en, d, s, Y, VLD, exp_y, exp_vld);
   endtask

   initial begin
      logic [7:0] pat;
      RST = 1'b1;
      EN  = 1'b0;
      D   = 8'h00;
      S   = 3'd0;

      // Reset for two cycles; enable is high to prove reset wins.
      step("reset0", 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0);
      step("reset1", 1'b1, 1'b1, 8'hFF, 3'd7, 1'b0, 1'b0);

      // Selected bit is the only one set.
      for (int i = 0; i < 8; i++) begin
         pat = 8'h01 << i;
         step($sformatf("hot%0d", i), 1'b0, 1'b1, pat, 3'(i), 1'b1, 1'b1);
      end

      // Selected bit is the only one clear; its neighbour is set.
      for (int i = 0; i < 8; i++) begin
         pat = ~(8'h01 << i);
         step($sformatf("cold%0d", i), 1'b0, 1'b1, pat, 3'(i), 1'b0, 1'b1);
         step($sformatf("nbr%0d", i), 1'b0, 1'b1, pat, 3'((i + 1) % 8), 1'b1, 1'b1);
      end

      // Single one at bit 4 swept by every select.
      for (int i = 0; i < 8; i++) begin
         step($sformatf("walk%0d", i), 1'b0, 1'b1, 8'h10, 3'(i), (i == 4), 1'b1);
      end

      // All-ones and all-zeros data.
      for (int i = 0; i < 8; i++) begin
         step($sformatf("ones%0d", i), 1'b0, 1'b1, 8'hFF, 3'(i), 1'b1, 1'b1);
         step($sformatf("zeros%0d", i), 1'b0, 1'b1, 8'h00, 3'(i), 1'b0, 1'b1);
      end

      // Load a one, then hold with EN low while the data goes to zero.
      step("load", 1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("hold%0d", i), 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      end

      // Reset in the middle of enabled operation, then resume.
      step("preload", 1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1);
      step("midrst", 1'b1, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0);
      step("resume", 1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1);

      // Enable low right after reset keeps the reset value.
      step("rst_again", 1'b1, 1'b0, 8'hFF, 3'd3, 1'b0, 1'b0);
      step("idle", 1'b0, 1'b0, 8'hFF, 3'd3, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
